// File: rtl/sc_io_ports_if.sv
// ============================================================================
// Module      : sc_io_ports_if
// Description : CPU-side bus for the memory-mapped I/O block: address, store
//               data, store enable and the combinational read-back word.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface sc_io_ports_if;
    logic [31:0] addr;
    logic [31:0] datain;
    logic        we;
    logic [31:0] io_read_data;

    // CPU data path side
    modport master (
        output addr,
        output datain,
        output we,
        input  io_read_data
    );

    // Peripheral side
    modport slave (
        input  addr,
        input  datain,
        input  we,
        output io_read_data
    );
endinterface

`default_nettype wire

// File: rtl/sc_io_ports.sv
// ============================================================================
// Module      : sc_io_ports
// Description : Memory-mapped I/O peripheral beside the data RAM. Holds three
//               32-bit output registers and the LED register, synchronises and
//               debounces two 5-bit switch banks, latches switch-change status
//               (write-1-to-clear) and raises a maskable registered interrupt.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sc_io_ports #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 16
) (
    input  logic            clock,
    input  logic            reset,
    sc_io_ports_if.slave    bus,
    input  logic [4:0]      in_port0,
    input  logic [4:0]      in_port1,
    output logic [31:0]     out_port0,
    output logic [31:0]     out_port1,
    output logic [31:0]     out_port2,
    output logic [9:0]      led,
    output logic            irq
);

    // ------------------------------------------------------------------------
    // Register map (word offsets, addr[6:2])
    // ------------------------------------------------------------------------
    localparam logic [4:0] c_OFF_OUT0   = 5'h00;
    localparam logic [4:0] c_OFF_OUT1   = 5'h01;
    localparam logic [4:0] c_OFF_OUT2   = 5'h02;
    localparam logic [4:0] c_OFF_LED    = 5'h03;
    localparam logic [4:0] c_OFF_IN0    = 5'h10;
    localparam logic [4:0] c_OFF_IN1    = 5'h11;
    localparam logic [4:0] c_OFF_STATUS = 5'h12;
    localparam logic [4:0] c_OFF_MASK   = 5'h13;

    // Debounce counter terminal value and increment
    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);

    // ------------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------------
    logic [4:0] offset;
    logic       io_we;

    assign offset = bus.addr[6:2];
    assign io_we  = bus.we & bus.addr[7];

    // Byte-lane and upper address bits carry no meaning for this block
    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.addr[31:8], bus.addr[1:0]};

    // ------------------------------------------------------------------------
    // Switch input path: one synchroniser + debouncer per bank
    // ------------------------------------------------------------------------
    logic [4:0] raw_in [2];
    logic [4:0] deb    [2];
    logic [1:0] accept;

    assign raw_in[0] = in_port0;
    assign raw_in[1] = in_port1;

    for (genvar b = 0; b < 2; b++) begin : g_bank
        logic [4:0]       sync1_q;
        logic [4:0]       sync2_q;
        logic [4:0]       deb_q;
        logic [CNT_W-1:0] cnt_q;
        logic             accept_w;

        // A change is accepted when the synchronised value has differed from
        // the accepted value on DEBOUNCE_CYCLES consecutive edges.
        assign accept_w  = (sync2_q != deb_q) && (cnt_q == c_CNT_LAST);
        assign accept[b] = accept_w;
        assign deb[b]    = deb_q;

        // Two-flop synchroniser followed by the stability counter; any return
        // to the accepted value restarts the count and drops the pending change.
        always_ff @(posedge clock) begin
            if (reset) begin
                sync1_q <= '0;
                sync2_q <= '0;
                deb_q   <= '0;
                cnt_q   <= '0;
            end else begin
                sync1_q <= raw_in[b];
                sync2_q <= sync1_q;
                if (sync2_q == deb_q) begin
                    cnt_q <= '0;
                end else if (accept_w) begin
                    deb_q <= sync2_q;
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_q + c_CNT_ONE;
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Control / output registers
    // ------------------------------------------------------------------------
    logic [31:0] out0_q,   out0_d;
    logic [31:0] out1_q,   out1_d;
    logic [31:0] out2_q,   out2_d;
    logic [9:0]  led_q,    led_d;
    logic [1:0]  status_q, status_d;
    logic [1:0]  mask_q,   mask_d;
    logic        irq_q,    irq_d;
    logic [1:0]  status_clr;

    // Next-state decode for CPU stores; a fresh acceptance beats a W1C on the
    // same bit, and irq looks at the post-update status and mask.
    always_comb begin
        out0_d     = out0_q;
        out1_d     = out1_q;
        out2_d     = out2_q;
        led_d      = led_q;
        mask_d     = mask_q;
        status_clr = 2'b00;

        if (io_we) begin
            case (offset)
                c_OFF_OUT0:   out0_d     = bus.datain;
                c_OFF_OUT1:   out1_d     = bus.datain;
                c_OFF_OUT2:   out2_d     = bus.datain;
                c_OFF_LED:    led_d      = bus.datain[9:0];
                c_OFF_STATUS: status_clr = bus.datain[1:0];
                c_OFF_MASK:   mask_d     = bus.datain[1:0];
                default:      ;
            endcase
        end

        status_d = (status_q & ~status_clr) | accept;
        irq_d    = |(status_d & mask_d);
    end

    // State registers for the output ports, LED, status, mask and interrupt
    always_ff @(posedge clock) begin
        if (reset) begin
            out0_q   <= '0;
            out1_q   <= '0;
            out2_q   <= '0;
            led_q    <= '0;
            status_q <= '0;
            mask_q   <= '0;
            irq_q    <= 1'b0;
        end else begin
            out0_q   <= out0_d;
            out1_q   <= out1_d;
            out2_q   <= out2_d;
            led_q    <= led_d;
            status_q <= status_d;
            mask_q   <= mask_d;
            irq_q    <= irq_d;
        end
    end

    // ------------------------------------------------------------------------
    // Read-back: zero-latency, ignores addr[7] (the CPU mux qualifies it)
    // ------------------------------------------------------------------------
    logic [31:0] rdata;

    // Combinational read mux over the register map
    always_comb begin
        rdata = 32'h0;
        case (offset)
            c_OFF_OUT0:   rdata = out0_q;
            c_OFF_OUT1:   rdata = out1_q;
            c_OFF_OUT2:   rdata = out2_q;
            c_OFF_LED:    rdata = {22'b0, led_q};
            c_OFF_IN0:    rdata = {27'b0, deb[0]};
            c_OFF_IN1:    rdata = {27'b0, deb[1]};
            c_OFF_STATUS: rdata = {30'b0, status_q};
            c_OFF_MASK:   rdata = {30'b0, mask_q};
            default:      rdata = 32'h0;
        endcase
    end

    assign bus.io_read_data = rdata;

    assign out_port0 = out0_q;
    assign out_port1 = out1_q;
    assign out_port2 = out2_q;
    assign led       = led_q;
    assign irq       = irq_q;

endmodule

`default_nettype wire
